// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end of the Sephirot VLIW core.
//
// Holds the bundle program counter, reads 256-bit bundles (four 64-bit eBPF
// syllables) from instruction memory, and presents one syllable per lane
// with its src/dst register fields already extracted. It also sequences
// program start and exit, applies branch redirects, and drives the lanes'
// pc_idle and decode_flush.
//
// Ports:
//   clk, reset           core clock, synchronous active-high reset
//   start, start_addr    begin a program at start_addr (accepted in IDLE only)
//   branch_taken/target  taken-branch redirect from a lane
//   exit_taken           a lane executed EXIT (wins over branch_taken)
//   imem_addr/rd_en      instruction-memory read port
//   imem_data            bundle, valid one cycle after an enabled read
//   syllable_0..3        per-lane syllable, 64'b0 (NOP) when no valid bundle
//   add_src_0..3         syllable_i[15:12]
//   add_dst_0..3         syllable_i[11:8]
//   pc_idle              no program running
//   decode_flush         lanes clear decode registers at the next edge
//   program_done         one-cycle pulse after exit
//   pc_out               current PC (trace)
//   fsm_state            current FSM state (debug): 0 IDLE, 1 RUN, 2 DONE
//
// Handshake: there is no backpressure. An enabled read at cycle t returns
// its bundle on imem_data at cycle t+1; bundle_valid marks whether that
// returned bundle belongs on the correct path and is shown to the lanes.
module fetch_stage #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_addr,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                exit_taken,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_rd_en,
  input  logic [255:0]        imem_data,
  output logic [63:0]         syllable_0,
  output logic [63:0]         syllable_1,
  output logic [63:0]         syllable_2,
  output logic [63:0]         syllable_3,
  output logic [3:0]          add_src_0,
  output logic [3:0]          add_src_1,
  output logic [3:0]          add_src_2,
  output logic [3:0]          add_src_3,
  output logic [3:0]          add_dst_0,
  output logic [3:0]          add_dst_1,
  output logic [3:0]          add_dst_2,
  output logic [3:0]          add_dst_3,
  output logic                pc_idle,
  output logic                decode_flush,
  output logic                program_done,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic                bundle_valid, bundle_valid_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      bundle_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      bundle_valid <= bundle_valid_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    bundle_valid_nxt = 1'b0;
    imem_rd_en       = 1'b0;
    pc_idle          = 1'b1;
    decode_flush     = 1'b0;
    program_done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_nxt    = start_addr;
          state_nxt = RUN;
        end
      end
      RUN: begin
        pc_idle    = 1'b0;
        imem_rd_en = 1'b1;
        if (exit_taken) begin
          // Exit wins over a same-cycle branch; PC is frozen for trace.
          decode_flush = 1'b1;
          state_nxt    = DONE;
        end else if (branch_taken) begin
          // The bundle read this cycle is wrong-path: leave bundle_valid
          // low so it shows as a NOP, then fetch the target.
          decode_flush = 1'b1;
          pc_nxt       = branch_target;
        end else begin
          pc_nxt           = pc + PC_WIDTH'(1);
          bundle_valid_nxt = 1'b1;
        end
      end
      DONE: begin
        program_done = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign fsm_state = state;

  assign syllable_0 = bundle_valid ? imem_data[63:0]    : 64'b0;
  assign syllable_1 = bundle_valid ? imem_data[127:64]  : 64'b0;
  assign syllable_2 = bundle_valid ? imem_data[191:128] : 64'b0;
  assign syllable_3 = bundle_valid ? imem_data[255:192] : 64'b0;

  // Register addresses come straight off the syllable so the register file
  // is read in the same cycle the lane samples the syllable.
  assign add_src_0 = syllable_0[15:12];
  assign add_src_1 = syllable_1[15:12];
  assign add_src_2 = syllable_2[15:12];
  assign add_src_3 = syllable_3[15:12];
  assign add_dst_0 = syllable_0[11:8];
  assign add_dst_1 = syllable_1[11:8];
  assign add_dst_2 = syllable_2[11:8];
  assign add_dst_3 = syllable_3[11:8];

endmodule
